// File: rtl/dvi_rx_tmds_decoder.sv
// TMDS receive channel: bit-slip symbol alignment keyed on control tokens, lock tracking, symbol decode.
// Optional lock/slip statistics outputs are built when DVI_RX_LOCK_STATS_EN is defined.
`timescale 1ns/1ps

// state     | meaning
// ST_SEARCH | hunting for TOKEN_RUN consecutive tokens, slipping one bit every SEARCH_DWELL cycles
// ST_LOCKED | offset frozen, dropping lock after LOSS_TIMEOUT cycles with no token
module dvi_rx_tmds_decoder #(
   parameter int TOKEN_RUN    = 8,
   parameter int SEARCH_DWELL = 4096,
   parameter int LOSS_TIMEOUT = 8192
) (
   input  logic       pixel_clock,
   input  logic       reset_n,
   input  logic [9:0] tmds_raw,
   output logic [7:0] data_out,
   output logic [1:0] ctrl_out,
   output logic       de_out,
   output logic       locked,
   output logic [3:0] slip_offset
`ifdef DVI_RX_LOCK_STATS_EN
   ,
   output logic [15:0] lock_loss_cnt,
   output logic [15:0] slip_cnt
`endif
);

   typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

   localparam logic [7:0]  RUN_LAST   = 8'(TOKEN_RUN - 1);
   localparam logic [15:0] DWELL_LOAD = 16'(SEARCH_DWELL - 1);
   localparam logic [15:0] GAP_LOAD   = 16'(LOSS_TIMEOUT - 1);

   logic [9:0]  prev_raw;
   logic [9:0]  sym_d;
   logic [9:0]  sym_q;
   logic [18:0] cat;
   logic        is_token;
   logic [1:0]  tok_ctrl;
   logic [7:0]  d_word;
   logic [7:0]  dec_data;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  run_q;
   logic [7:0]  run_d;
   logic [15:0] dwell_q;
   logic [15:0] dwell_d;
   logic [15:0] gap_q;
   logic [15:0] gap_d;
   logic [3:0]  offset_d;

   // Offset 9 reaches bit 18 at most, so the top bit of the new word only feeds prev_raw.
   assign cat = {tmds_raw[8:0], prev_raw};

   always_comb begin
      sym_d = prev_raw;
      for (int k = 1; k < 10; k++) begin
         if (slip_offset == 4'(k)) sym_d = cat[k +: 10];
      end
   end

   always_comb begin
      is_token = 1'b1;
      tok_ctrl = 2'b00;
      case (sym_q)
         10'b1101010100: tok_ctrl = 2'b00;
         10'b0010101011: tok_ctrl = 2'b01;
         10'b0101010100: tok_ctrl = 2'b10;
         10'b1010101011: tok_ctrl = 2'b11;
         default:        is_token = 1'b0;
      endcase
   end

   always_comb begin
      d_word      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
      dec_data    = '0;
      dec_data[0] = d_word[0];
      for (int i = 1; i < 8; i++) begin
         dec_data[i] = sym_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (!reset_n) begin
         prev_raw <= '0;
         sym_q    <= '0;
         data_out <= '0;
         ctrl_out <= '0;
         de_out   <= 1'b0;
      end else begin
         prev_raw <= tmds_raw;
         sym_q    <= sym_d;
         if (is_token) begin
            de_out   <= 1'b0;
            ctrl_out <= tok_ctrl;
         end else begin
            de_out   <= 1'b1;
            data_out <= dec_data;
         end
      end
   end

   // Dwell and gap timers count down; a freshly loaded timer corresponds to zero elapsed cycles.
   always_ff @(posedge pixel_clock) begin
      if (!reset_n) begin
         state_q     <= ST_SEARCH;
         run_q       <= '0;
         dwell_q     <= DWELL_LOAD;
         gap_q       <= GAP_LOAD;
         slip_offset <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         dwell_q     <= dwell_d;
         gap_q       <= gap_d;
         slip_offset <= offset_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      dwell_d  = dwell_q;
      gap_d    = gap_q;
      offset_d = slip_offset;
      case (state_q)
         ST_SEARCH: begin
            if (is_token) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
            else          run_d = '0;
            if (is_token && (run_q == RUN_LAST)) begin
               state_d = ST_LOCKED;
               dwell_d = DWELL_LOAD;
               gap_d   = GAP_LOAD;
            end else if (dwell_q == '0) begin
               offset_d = (slip_offset == 4'd9) ? 4'd0 : slip_offset + 4'd1;
               run_d    = '0;
               dwell_d  = DWELL_LOAD;
            end else begin
               dwell_d = dwell_q - 16'd1;
            end
         end
         ST_LOCKED: begin
            if (is_token) begin
               gap_d = GAP_LOAD;
            end else if (gap_q == '0) begin
               state_d = ST_SEARCH;
               run_d   = '0;
               dwell_d = DWELL_LOAD;
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   assign locked = (state_q == ST_LOCKED);

`ifdef DVI_RX_LOCK_STATS_EN
   logic slip_evt;
   logic loss_evt;

   assign slip_evt = (state_q == ST_SEARCH) && (offset_d != slip_offset);
   assign loss_evt = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

   always_ff @(posedge pixel_clock) begin
      if (!reset_n) begin
         lock_loss_cnt <= '0;
         slip_cnt      <= '0;
      end else begin
         if (loss_evt && (lock_loss_cnt != 16'hFFFF)) lock_loss_cnt <= lock_loss_cnt + 16'd1;
         if (slip_evt && (slip_cnt != 16'hFFFF))      slip_cnt      <= slip_cnt + 16'd1;
      end
   end
`endif

endmodule
